muldiv_hilo_ctrl: RTL and testbench
===================================

Name: muldiv_hilo_ctrl

Overview:
- Sits directly upstream of the sequential Booth multiplier and issues multiply operations to it over a start/done handshake.
- Captures the 2*WIDTH product into the architectural HI/LO registers.
- Serves MFHI/MFLO/MTHI/MTLO and stalls the MIPS pipeline while a multiply is in flight.
- Flags a multiplier that never returns done.

Parameters:
WIDTH, 32, operand and HI/LO register width
MAX_CYCLES, 64, cycles allowed in WAIT before timeout error

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
op_valid  input  1  pipeline presents a HI/LO operation this cycle
op_code  input  3  001 MULT, 010 MULTU, 011 MTHI, 100 MTLO, 101 MFHI, 110 MFLO, others no-op
rs_val  input  WIDTH  multiplicand / MTHI/MTLO source
rt_val  input  WIDTH  multiplier
stall  output  1  combinational; pipeline must hold the op and re-present it
rd_val  output  WIDTH  MFHI/MFLO result, registered
rd_valid  output  1  one-cycle pulse qualifying rd_val
mul_start  output  1  one-cycle pulse to multiplier
mul_a  output  WIDTH  latched multiplicand
mul_b  output  WIDTH  latched multiplier
mul_signed  output  1  1 for MULT, 0 for MULTU
mul_done  input  1  multiplier result valid, single-cycle pulse
mul_product  input  2*WIDTH  product, valid with mul_done
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register
busy  output  1  state is WAIT
timeout_err  output  1  sticky; set on multiply timeout

Behaviour:
- Reset (async, immediate): state IDLE; hi, lo, rd_val, mul_a, mul_b and cycle counter cleared to 0; rd_valid, mul_start, mul_signed, timeout_err cleared to 0.
- FSM has two states, IDLE and WAIT.
- IDLE + op_valid + MULT/MULTU:
  - Latch rs_val→mul_a, rt_val→mul_b; set mul_signed.
  - Pulse mul_start for exactly 1 cycle on the next edge.
  - Go to WAIT and clear the counter.
  - stall=0 in the issuing cycle.
- WAIT:
  - busy=1; counter increments each cycle.
  - On mul_done: hi←mul_product[2W-1:W], lo←mul_product[W-1:0], go IDLE.
  - hi/lo become visible the cycle after mul_done.
- stall = op_valid & busy & (op_code ∈ {MULT, MULTU, MTHI, MTLO, MFHI, MFLO}). Invalid op codes never stall.
- Same cycle as mul_done: stall is still 1 because state is WAIT; the re-presented op is served the following cycle using the new hi/lo.
- MTHI/MTLO in IDLE: hi or lo←rs_val at the next edge.
- MFHI/MFLO in IDLE: rd_val←hi or lo at the next edge; rd_valid=1 for that one cycle.
  - Back-to-back MF ops give consecutive rd_valid pulses.
  - MFHI issued the cycle after MTHI returns the new value (1-cycle write latency, no bypass needed).
- Timeout:
  - If the counter reaches MAX_CYCLES in WAIT without mul_done: timeout_err←1 (sticky until rst), go IDLE, hi/lo unchanged.
  - A late mul_done arriving in IDLE is ignored.
- mul_done in IDLE is always ignored. mul_start is never asserted while busy.
- rst asserted mid-multiply: everything returns to reset values at once; any following mul_done is ignored.

Test Plan:
- Reset then MFHI, MFLO → rd_valid pulses with rd_val=0, 0; stall=0 throughout.
- MULT rs=0xFFFFFFFE(-2), rt=3, mul_signed=1; model returns 0xFFFFFFFF_FFFFFFFA after 33 cycles → stall held on MFLO during WAIT; MFHI/MFLO then return 0xFFFFFFFF/0xFFFFFFFA.
- MULTU rs=0xFFFFFFFF, rt=2, mul_signed=0; product 0x00000001_FFFFFFFE → hi=1, lo=0xFFFFFFFE; exactly one mul_start pulse seen.
- MTHI 0x12345678, then MFHI next cycle → rd_val=0x12345678. MTLO during WAIT → stall=1 until the cycle after mul_done, then lo written.
- Model never asserts mul_done → timeout_err=1 after 64 WAIT cycles, busy=0, hi/lo unchanged; late mul_done ignored.
- Assert rst 5 cycles into WAIT, then pulse mul_done → hi=lo=0, busy=0, timeout_err=0.

Source files
------------

// File: rtl/muldiv_hilo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_hilo_ctrl
// Brief    : HI/LO register controller for a MIPS pipeline. Issues multiplies
//            to a sequential multiplier over a start/done handshake, captures
//            the product into HI/LO, serves MFHI/MFLO/MTHI/MTLO and stalls
//            the pipeline while a multiply is in flight. A multiplier that
//            never answers is flagged by a sticky timeout error.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_hilo_ctrl #(
  parameter int WIDTH      = 32,
  parameter int MAX_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               op_valid,
  input  logic [2:0]         op_code,
  input  logic [WIDTH-1:0]   rs_val,
  input  logic [WIDTH-1:0]   rt_val,
  output logic               stall,
  output logic [WIDTH-1:0]   rd_val,
  output logic               rd_valid,
  output logic               mul_start,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  output logic               mul_signed,
  input  logic               mul_done,
  input  logic [2*WIDTH-1:0] mul_product,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo,
  output logic               busy,
  output logic               timeout_err
);

  localparam logic [2:0] c_OP_MULT  = 3'b001;
  localparam logic [2:0] c_OP_MULTU = 3'b010;
  localparam logic [2:0] c_OP_MTHI  = 3'b011;
  localparam logic [2:0] c_OP_MTLO  = 3'b100;
  localparam logic [2:0] c_OP_MFHI  = 3'b101;
  localparam logic [2:0] c_OP_MFLO  = 3'b110;

  localparam int c_CNT_W = $clog2(MAX_CYCLES + 1);
  // Value held by the counter during the last permitted WAIT cycle.
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(MAX_CYCLES - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_mul_start;
  logic [WIDTH-1:0]   r_mul_a;
  logic [WIDTH-1:0]   r_mul_b;
  logic               r_mul_signed;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_rd_val;
  logic               r_rd_valid;
  logic               r_timeout_err;

  logic w_busy;
  logic w_hilo_op;
  logic w_serve;
  logic w_issue;
  logic w_done_ok;
  logic w_timeout;

  // Decode the current op and the handshake events of this cycle.
  always_comb begin
    w_busy    = (r_state == S_WAIT);
    w_hilo_op = (op_code == c_OP_MULT) || (op_code == c_OP_MULTU) ||
                (op_code == c_OP_MTHI) || (op_code == c_OP_MTLO) ||
                (op_code == c_OP_MFHI) || (op_code == c_OP_MFLO);
    // Only IDLE serves ops; in WAIT every HI/LO op is held by the stall.
    w_serve   = (r_state == S_IDLE) && op_valid;
    w_issue   = w_serve && ((op_code == c_OP_MULT) || (op_code == c_OP_MULTU));
    // A done pulse seen in IDLE (late or spurious) is deliberately ignored.
    w_done_ok = w_busy && mul_done;
    w_timeout = w_busy && !mul_done && (r_cnt == c_CNT_LAST);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: leave WAIT on the product or on timeout.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_issue) w_state_nxt = S_WAIT;
      S_WAIT:  if (w_done_ok || w_timeout) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // WAIT cycle counter and sticky timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt         <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_issue) begin
        r_cnt <= '0;
      end else if (w_busy) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_timeout) begin
        r_timeout_err <= 1'b1;
      end
    end
  end

  // Multiplier request: latch operands and pulse start once per issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mul_start  <= 1'b0;
      r_mul_a      <= '0;
      r_mul_b      <= '0;
      r_mul_signed <= 1'b0;
    end else begin
      r_mul_start <= w_issue;
      if (w_issue) begin
        r_mul_a      <= rs_val;
        r_mul_b      <= rt_val;
        r_mul_signed <= (op_code == c_OP_MULT);
      end
    end
  end

  // HI/LO update from the multiplier product or from MTHI/MTLO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_done_ok) begin
      r_hi <= mul_product[2*WIDTH-1:WIDTH];
      r_lo <= mul_product[WIDTH-1:0];
    end else if (w_serve && (op_code == c_OP_MTHI)) begin
      r_hi <= rs_val;
    end else if (w_serve && (op_code == c_OP_MTLO)) begin
      r_lo <= rs_val;
    end
  end

  // MFHI/MFLO read port with a one-cycle valid pulse per served read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_val   <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      if (w_serve && (op_code == c_OP_MFHI)) begin
        r_rd_val   <= r_hi;
        r_rd_valid <= 1'b1;
      end else if (w_serve && (op_code == c_OP_MFLO)) begin
        r_rd_val   <= r_lo;
        r_rd_valid <= 1'b1;
      end
    end
  end

  assign stall       = op_valid && w_busy && w_hilo_op;
  assign busy        = w_busy;
  assign rd_val      = r_rd_val;
  assign rd_valid    = r_rd_valid;
  assign mul_start   = r_mul_start;
  assign mul_a       = r_mul_a;
  assign mul_b       = r_mul_b;
  assign mul_signed  = r_mul_signed;
  assign hi          = r_hi;
  assign lo          = r_lo;
  assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_hilo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_hilo_ctrl
// Brief    : Self-checking bench for muldiv_hilo_ctrl. A behavioural
//            multiplier answers the start/done handshake and a plain HI/LO
//            model predicts every architectural result.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_hilo_ctrl;

  localparam int W    = 32;
  localparam int MAXC = 64;

  localparam logic [2:0] c_MULT  = 3'b001;
  localparam logic [2:0] c_MULTU = 3'b010;
  localparam logic [2:0] c_MTHI  = 3'b011;
  localparam logic [2:0] c_MTLO  = 3'b100;
  localparam logic [2:0] c_MFHI  = 3'b101;
  localparam logic [2:0] c_MFLO  = 3'b110;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           op_valid = 1'b0;
  logic [2:0]     op_code = 3'b000;
  logic [W-1:0]   rs_val = '0;
  logic [W-1:0]   rt_val = '0;
  logic           stall;
  logic [W-1:0]   rd_val;
  logic           rd_valid;
  logic           mul_start;
  logic [W-1:0]   mul_a;
  logic [W-1:0]   mul_b;
  logic           mul_signed;
  logic           mul_done = 1'b0;
  logic [2*W-1:0] mul_product = '0;
  logic [W-1:0]   hi;
  logic [W-1:0]   lo;
  logic           busy;
  logic           timeout_err;

  int checks   = 0;
  int failures = 0;
  int starts   = 0;

  // Architectural HI/LO reference.
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  muldiv_hilo_ctrl #(.WIDTH(W), .MAX_CYCLES(MAXC)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code),
    .rs_val(rs_val), .rt_val(rt_val), .stall(stall), .rd_val(rd_val),
    .rd_valid(rd_valid), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_signed(mul_signed), .mul_done(mul_done), .mul_product(mul_product),
    .hi(hi), .lo(lo), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Count start pulses as the multiplier would see them.
  always @(posedge clk) if (mul_start === 1'b1) starts++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [2:0] code, input logic [W-1:0] a, input logic [W-1:0] b);
    op_valid = 1'b1;
    op_code  = code;
    rs_val   = a;
    rt_val   = b;
  endtask

  task automatic idle_in();
    op_valid = 1'b0;
    op_code  = 3'b000;
  endtask

  // Mathematical product of two WIDTH-bit operands.
  function automatic logic [63:0] ref_prod(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa;
    longint sb;
    if (sgn) begin
      sa = $signed(a);
      sb = $signed(b);
      return sa * sb;
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  // Non-multiply op served from IDLE; left presented for back-to-back use.
  task automatic simple_op(input logic [2:0] code, input logic [W-1:0] v);
    logic [W-1:0] exp_rd;
    logic         exp_v;
    present(code, v, ~v);
    #1 chk("op_stall", stall, 0);
    exp_v  = (code == c_MFHI) || (code == c_MFLO);
    exp_rd = (code == c_MFHI) ? m_hi : m_lo;
    tick();
    if (code == c_MTHI) m_hi = v;
    if (code == c_MTLO) m_lo = v;
    chk("rd_valid", rd_valid, exp_v);
    if (exp_v) chk("rd_val", rd_val, exp_rd);
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    chk("no_start", mul_start, 0);
  endtask

  // Multiply with a given latency; an optional HI/LO op waits under stall.
  task automatic run_mul(input bit sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int lat, input logic [2:0] pend, input logic [W-1:0] pv);
    int           s0;
    logic [63:0]  exp;
    logic [63:0]  prod;
    s0 = starts;
    present(sgn ? c_MULT : c_MULTU, a, b);
    #1 chk("issue_stall", stall, 0);
    tick();
    chk("mul_start", mul_start, 1);
    chk("busy_wait", busy, 1);
    chk("mul_a", mul_a, a);
    chk("mul_b", mul_b, b);
    chk("mul_signed", mul_signed, sgn);
    // Behavioural multiplier works from the operands it was handed.
    prod = ref_prod(mul_signed, mul_a, mul_b);
    exp  = ref_prod(sgn, a, b);
    if (pend != 3'b000) present(pend, pv, ~pv);
    else idle_in();
    for (int i = 1; i < lat; i++) begin
      #1;
      if (pend != 3'b000) chk("wait_stall", stall, 1);
      tick();
      chk("start_pulse", mul_start, 0);
      chk("still_busy", busy, 1);
    end
    mul_done    = 1'b1;
    mul_product = prod;
    #1;
    if (pend != 3'b000) chk("done_stall", stall, 1);
    tick();
    mul_done    = 1'b0;
    mul_product = {$urandom, $urandom};
    m_hi = exp[63:32];
    m_lo = exp[31:0];
    chk("busy_done", busy, 0);
    chk("hi_prod", hi, m_hi);
    chk("lo_prod", lo, m_lo);
    if (pend != 3'b000) simple_op(pend, pv);
    idle_in();
    chk("one_start", starts - s0, 1);
  endtask

  initial begin
    logic [2:0]   codes [8];
    logic [2:0]   pends [5];
    logic [2:0]   c;
    int           n;
    logic [W-1:0] x;

    codes = '{c_MULT, c_MULTU, c_MTHI, c_MTLO, c_MFHI, c_MFLO, 3'b000, 3'b111};
    pends = '{3'b000, c_MTHI, c_MTLO, c_MFHI, c_MFLO};

    // Reset state
    tick(); tick();
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_start", mul_start, 0);
    chk("rst_signed", mul_signed, 0);
    chk("rst_tmo", timeout_err, 0);
    chk("rst_rdv", rd_valid, 0);
    rst = 1'b0;
    tick();

    // MFHI then MFLO back to back after reset
    simple_op(c_MFHI, 32'h0);
    simple_op(c_MFLO, 32'h0);
    idle_in();
    tick();
    chk("rdv_drop", rd_valid, 0);

    // Directed multiplies
    run_mul(1'b1, 32'hFFFF_FFFE, 32'd3, 33, c_MFLO, 32'h0);
    simple_op(c_MFHI, 32'h0);
    chk("mult_hi", rd_val, 32'hFFFF_FFFF);
    idle_in();
    run_mul(1'b0, 32'hFFFF_FFFF, 32'd2, 5, 3'b000, 32'h0);
    chk("multu_hi", hi, 32'h1);
    chk("multu_lo", lo, 32'hFFFF_FFFE);

    // MTHI followed immediately by MFHI
    simple_op(c_MTHI, 32'h1234_5678);
    simple_op(c_MFHI, 32'h0);
    chk("mthi_mfhi", rd_val, 32'h1234_5678);
    idle_in();

    // MTLO held under stall until the multiply completes
    run_mul(1'b1, 32'h0000_1234, 32'h8000_0000, 7, c_MTLO, 32'hCAFE_F00D);
    chk("mtlo_after", lo, 32'hCAFE_F00D);

    // Randomised operation stream
    for (int k = 0; k < 24; k++) begin
      c = codes[$urandom_range(7, 0)];
      x = $urandom;
      if (c == c_MULT || c == c_MULTU)
        run_mul(c == c_MULT, x, $urandom, $urandom_range(40, 1),
                pends[$urandom_range(4, 0)], $urandom);
      else begin
        simple_op(c, x);
        if ($urandom_range(1, 0) == 1) idle_in();
      end
    end
    idle_in();
    tick();

    // Multiplier never answers
    present(c_MULT, $urandom, $urandom);
    tick();
    idle_in();
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("tmo_cycles", n, MAXC);
    chk("tmo_err", timeout_err, 1);
    chk("tmo_busy", busy, 0);
    chk("tmo_hi", hi, m_hi);
    chk("tmo_lo", lo, m_lo);
    mul_done    = 1'b1;
    mul_product = {$urandom, $urandom};
    tick();
    mul_done = 1'b0;
    tick();
    chk("late_hi", hi, m_hi);
    chk("late_lo", lo, m_lo);
    chk("late_busy", busy, 0);
    simple_op(c_MFLO, 32'h0);
    idle_in();
    chk("tmo_sticky", timeout_err, 1);

    // Reset in the middle of a multiply
    present(c_MULTU, $urandom, $urandom);
    tick();
    idle_in();
    repeat (5) tick();
    #2 rst = 1'b1;
    #1;
    m_hi = '0;
    m_lo = '0;
    chk("arst_busy", busy, 0);
    chk("arst_hi", hi, 0);
    chk("arst_tmo", timeout_err, 0);
    #2 rst = 1'b0;
    tick();
    mul_done    = 1'b1;
    mul_product = {$urandom | 32'h1, $urandom | 32'h1};
    tick();
    mul_done = 1'b0;
    tick();
    chk("post_hi", hi, 0);
    chk("post_lo", lo, 0);
    chk("post_busy", busy, 0);
    chk("post_tmo", timeout_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
